jtframe_logo_ctrl: RTL

Sequencer for the logo overlay. Decides when the overlay is shown and for how long, and produces the overlay enable plus a 3-bit fade level. Driven by frame timing from the core's video (vs, lvbl) and by system events (ROM download, user skip, OSD re-show request). Sits between the framework's system signals and the show_en/fade inputs of the logo overlay.

---
 rtl/jtframe_logo_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/jtframe_logo_ctrl.sv
// Logo overlay sequencer: keeps the overlay on while a ROM download is in
// progress, holds it at full intensity for a while after the download ends,
// fades it out and then switches it off. The user can skip the logo, and the
// OSD can bring it back.
//
// Handshake note: this block has no valid/ready interfaces. Every input is a
// level sampled on the clk edge. The only edge-sensitive inputs are vs, whose
// edge is taken on pxl_cen clocks only, and show_req, whose edge is taken on
// every clk.
module jtframe_logo_ctrl #(
  parameter int HOLD_FRAMES = 120,  // frames at full intensity (1..255)
  parameter int FADE_FRAMES = 4     // frames per fade step (1..255)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       vs,
  input  logic       lvbl,
  input  logic       downloading,
  input  logic       skip,
  input  logic       show_req,
  output logic       show_en,
  output logic [2:0] fade,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_SHOW = 2'd0,
    ST_HOLD = 2'd1,
    ST_FADE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] FADE_LAST = 8'(FADE_FRAMES - 1);

  state_t     st_q, st_d;
  logic [2:0] fade_q, fade_d;
  logic [7:0] frm_q, frm_d;
  logic [7:0] stp_q, stp_d;
  logic       vs_q;
  logic       req_q;
  logic       show_en_q, show_en_d;
  logic       busy_q, busy_d;

  logic       tick;
  logic       req_edge;
  logic       unused_lvbl;

  // Frame timing comes from vs alone; lvbl is part of the video bundle but
  // carries no extra information for this sequencer.
  assign unused_lvbl = lvbl;

  assign tick     = pxl_cen & vs & ~vs_q;
  assign req_edge = show_req & ~req_q;

  // Edge-detection history: vs follows the pixel enable, show_req every clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b0;
      req_q <= 1'b0;
    end else begin
      if (pxl_cen) vs_q <= vs;
      req_q <= show_req;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_SHOW;
      fade_q    <= 3'd7;
      frm_q     <= 8'd0;
      stp_q     <= 8'd0;
      show_en_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      st_q      <= st_d;
      fade_q    <= fade_d;
      frm_q     <= frm_d;
      stp_q     <= stp_d;
      show_en_q <= show_en_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: downloading > skip > show_req > frame-tick advance
  always_comb begin
    st_d   = st_q;
    fade_d = fade_q;
    frm_d  = frm_q;
    stp_d  = stp_q;
    if (downloading) begin
      st_d   = ST_SHOW;
      fade_d = 3'd7;
      frm_d  = 8'd0;
      stp_d  = 8'd0;
    end else begin
      case (st_q)
        ST_SHOW: begin
          // skip has no effect here; the hold period always starts
          st_d   = ST_HOLD;
          fade_d = 3'd7;
          frm_d  = 8'd0;
        end
        ST_HOLD: begin
          if (skip) begin
            st_d   = ST_DONE;
            fade_d = 3'd0;
          end else if (tick) begin
            if (frm_q == HOLD_LAST) begin
              st_d  = ST_FADE;
              stp_d = 8'd0;
            end else begin
              frm_d = frm_q + 8'd1;
            end
          end
        end
        ST_FADE: begin
          if (skip) begin
            st_d   = ST_DONE;
            fade_d = 3'd0;
          end else if (tick) begin
            if (stp_q == FADE_LAST) begin
              stp_d = 8'd0;
              // fade=0 is shown for a full step before switching off
              if (fade_q == 3'd0) st_d = ST_DONE;
              else                fade_d = fade_q - 3'd1;
            end else begin
              stp_d = stp_q + 8'd1;
            end
          end
        end
        ST_DONE: begin
          fade_d = 3'd0;
          if (req_edge) begin
            st_d   = ST_HOLD;
            fade_d = 3'd7;
            frm_d  = 8'd0;
            stp_d  = 8'd0;
          end
        end
        default: begin
          st_d   = ST_SHOW;
          fade_d = 3'd7;
          frm_d  = 8'd0;
          stp_d  = 8'd0;
        end
      endcase
    end
    show_en_d = (st_d != ST_DONE);
    busy_d    = (st_d != ST_DONE);
  end

  assign show_en   = show_en_q;
  assign fade      = fade_q;
  assign busy      = busy_q;
  assign state_dbg = st_q;

endmodule
